// File: rtl/ghostbus_host_pkg.sv
// ghostbus_host_pkg
//   Shared definitions for the ghostbus host and its responders. It holds the
//   default bus widths and the host FSM state encoding.
package ghostbus_host_pkg;

    localparam int GB_AW = 24;   // bus address width
    localparam int GB_DW = 32;   // bus data width
    localparam int GB_LW = 8;    // burst length field width

    typedef enum logic [1:0] {
        GB_ST_IDLE  = 2'd0,
        GB_ST_WRITE = 2'd1,
        GB_ST_RWAIT = 2'd2,
        GB_ST_RESP  = 2'd3
    } gb_state_t;

endpackage

// File: rtl/ghostbus_host_lat.sv
// ghostbus_host_lat
//   Read-latency down-counter for the ghostbus host.
//   The load input presets the count so that zero rises on the RD_LAT-th
//   cycle spent waiting.
//   Ports:
//     clk   in   bus clock
//     rst   in   asynchronous active-high reset
//     load  in   preset the count at the start of a read beat
//     dec   in   count down, stopping at zero
//     zero  out  terminal count reached; the read data is valid this cycle
module ghostbus_host_lat #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    // The capture happens on the cycle in which the count is zero. Loading
    // RD_LAT-1 therefore gives RD_LAT wait cycles.
    localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(RD_LAT - 1);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ghostbus_host.sv
// ghostbus_host
//   Ghostbus initiator. It converts valid/ready request beats into bus cycles
//   and returns write acks or read data on a valid/ready response channel.
//   Reads are auto-incrementing bursts of req_len+1 beats. Only one
//   transaction is in flight at a time.
//   Ports:
//     gb_clk, rst                       clock, async active-high reset
//     req_valid/req_ready               request handshake
//     req_we/req_addr/req_wdata/req_len request fields
//     rsp_valid/rsp_ready               response handshake
//     rsp_we/rsp_data/rsp_last          response fields
//     gb_addr/gb_dout/gb_din/gb_we      ghostbus signals
//     busy                              transaction in progress
//   Bus timing: gb_addr is launched on the accept edge, or on the edge of the
//   previous beat's handshake. gb_din is sampled on the RD_LAT-th edge after
//   that launch. gb_addr stays constant over the whole wait.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   IDLE  | ready for a request; bus outputs hold their last values
//   WRITE | gb_we pulse for one cycle at gb_addr/gb_dout
//   RWAIT | address is on the bus; waiting out the read latency
//   RESP  | response is offered and held until rsp_ready
module ghostbus_host
    import ghostbus_host_pkg::*;
#(
    parameter int AW     = GB_AW,
    parameter int DW     = GB_DW,
    parameter int LW     = GB_LW,
    parameter int RD_LAT = 1
) (
    input  logic          gb_clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic          busy
);

    if (RD_LAT < 1) begin : g_lat_check
        $error("ghostbus_host: RD_LAT must be at least 1");
    end

    gb_state_t     state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat_q;
    logic          lat_load;
    logic          lat_dec;
    logic          lat_zero;

    assign req_ready = (state == GB_ST_IDLE);
    assign busy      = (state != GB_ST_IDLE);

    // Preload the latency counter on every edge that launches a read address.
    always_comb begin
        lat_load = 1'b0;
        if (state == GB_ST_IDLE && req_valid && !req_we) begin
            lat_load = 1'b1;
        end
        if (state == GB_ST_RESP && rsp_ready && !rsp_last) begin
            lat_load = 1'b1;
        end
    end

    assign lat_dec = (state == GB_ST_RWAIT);

    ghostbus_host_lat #(
        .RD_LAT (RD_LAT)
    ) u_lat (
        .clk  (gb_clk),
        .rst  (rst),
        .load (lat_load),
        .dec  (lat_dec),
        .zero (lat_zero)
    );

    always_ff @(posedge gb_clk or posedge rst) begin
        if (rst) begin
            state     <= GB_ST_IDLE;
            gb_addr   <= '0;
            gb_dout   <= '0;
            gb_we     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            gb_we <= 1'b0;
            case (state)
                GB_ST_IDLE: begin
                    if (req_valid) begin
                        gb_addr <= req_addr;
                        len_q   <= req_len;
                        beat_q  <= '0;
                        if (req_we) begin
                            // gb_dout only changes for writes, so reads leave it as it was.
                            gb_dout <= req_wdata;
                            gb_we   <= 1'b1;
                            state   <= GB_ST_WRITE;
                        end else begin
                            state   <= GB_ST_RWAIT;
                        end
                    end
                end
                GB_ST_WRITE: begin
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b1;
                    rsp_data  <= '0;
                    rsp_last  <= 1'b1;
                    state     <= GB_ST_RESP;
                end
                GB_ST_RWAIT: begin
                    if (lat_zero) begin
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                        rsp_data  <= gb_din;
                        rsp_last  <= (beat_q == len_q);
                        state     <= GB_ST_RESP;
                    end
                end
                GB_ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= GB_ST_IDLE;
                        end else begin
                            // The address wraps at 2^AW and the burst carries on.
                            gb_addr <= gb_addr + 1'b1;
                            beat_q  <= beat_q + 1'b1;
                            state   <= GB_ST_RWAIT;
                        end
                    end
                end
                default: state <= GB_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghostbus_host.sv
// tb_ghostbus_host
//   Bench for ghostbus_host. It builds two instances: RD_LAT=1 for the main
//   traffic and RD_LAT=3 for the latency check. Expected response beats go into
//   a queue, and one negedge process compares the RD_LAT=1 instance against
//   that queue on every cycle.
module tb_ghostbus_host;

    localparam int LAT1 = 1;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        last;
    } exp_t;

    logic        gb_clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_last;
    logic [31:0] rsp_data;
    logic [23:0] gb_addr;
    logic [31:0] gb_dout, gb_din;
    logic        gb_we, busy;

    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_we3, rsp_last3;
    logic [23:0] req_addr3, gb_addr3;
    logic [31:0] rsp_data3, gb_dout3, gb_din3;
    logic        gb_we3, busy3;
    logic [31:0] s1, s2;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int phase = 0;      // 0 idle, 1 waiting for a beat, 2 beat offered
    int wait_cnt = 0;
    bit slow_rsp = 1'b0;
    exp_t expq[$];
    exp_t cur;

    logic [31:0] mem1 [logic [23:0]];
    logic [31:0] mem3 [logic [23:0]];

    ghostbus_host #(.RD_LAT(LAT1)) u_dut (
        .gb_clk(gb_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_din(gb_din), .gb_we(gb_we),
        .busy(busy)
    );

    ghostbus_host #(.RD_LAT(3)) u_dut3 (
        .gb_clk(gb_clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(1'b0),
        .req_addr(req_addr3), .req_wdata(32'h0), .req_len(8'h0),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_we(rsp_we3),
        .rsp_data(rsp_data3), .rsp_last(rsp_last3),
        .gb_addr(gb_addr3), .gb_dout(gb_dout3), .gb_din(gb_din3), .gb_we(gb_we3),
        .busy(busy3)
    );

    initial begin
        gb_clk = 1'b0;
        forever #5 gb_clk = ~gb_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Responder model. Any address that was never written returns {A5, addr}.
    function automatic logic [31:0] peek1(input logic [23:0] a);
        return mem1.exists(a) ? mem1[a] : {8'hA5, a};
    endfunction

    function automatic logic [31:0] peek3(input logic [23:0] a);
        return mem3.exists(a) ? mem3[a] : {8'hA5, a};
    endfunction

    // RD_LAT=1 responder: data for the current gb_addr is ready before the next edge.
    always @(negedge gb_clk) gb_din = peek1(gb_addr);

    always @(posedge gb_clk) begin
        if (!rst && gb_we) begin
            mem1[gb_addr] = gb_dout;
            n_wr++;
        end
    end

    // RD_LAT=3 responder: two register stages after gb_addr.
    always @(posedge gb_clk) begin
        s1 <= peek3(gb_addr3);
        s2 <= s1;
    end
    assign gb_din3 = s2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the transaction model.
    always @(negedge gb_clk) begin
        if (!rst) begin
            if (phase == 1) begin
                wait_cnt--;
                if (wait_cnt == 0) phase = 2;
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(phase == 2));
            chk("busy", 64'(busy), 64'(phase != 0));
            chk("req_ready", 64'(req_ready), 64'(phase == 0));
            if (phase != 0 && expq.size() > 0) begin
                cur = expq[0];
                chk("gb_addr", 64'(gb_addr), 64'(cur.addr));
                chk("gb_we", 64'(gb_we), 64'(phase == 1 && cur.we));
                if (gb_we) chk("gb_dout", 64'(gb_dout), 64'(cur.wdata));
                if (phase == 2) begin
                    chk("rsp_we", 64'(rsp_we), 64'(cur.we));
                    chk("rsp_data", 64'(rsp_data), 64'(cur.rdata));
                    chk("rsp_last", 64'(rsp_last), 64'(cur.last));
                end
            end else begin
                chk("gb_we_idle", 64'(gb_we), 64'd0);
            end
            if (phase == 0 && req_valid && expq.size() > 0) begin
                phase    = 1;
                wait_cnt = expq[0].we ? 2 : LAT1 + 1;
            end else if (phase == 2 && rsp_ready && expq.size() > 0) begin
                cur = expq.pop_front();
                if (cur.last) begin
                    phase = 0;
                end else begin
                    phase    = 1;
                    wait_cnt = LAT1 + 1;
                end
            end
        end
    end

    initial begin
        int k = 0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge gb_clk); #1;
            k++;
            rsp_ready = slow_rsp ? (k % 3 == 0) : 1'b1;
        end
    end

    task automatic push(input logic we, input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic last);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.last = last;
        expq.push_back(e);
    endtask

    task automatic send(input logic we, input logic [23:0] a, input logic [31:0] wd,
                        input logic [7:0] len);
        int n = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_len = len; req_valid = 1'b1;
        @(negedge gb_clk);
        while (!req_ready && n < 50) begin
            @(negedge gb_clk);
            n++;
        end
        chk("req_accept", 64'(req_ready), 64'd1);
        @(posedge gb_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((phase != 0 || expq.size() != 0) && n < 400) begin
            @(negedge gb_clk);
            n++;
        end
        chk(nm, 64'(expq.size()), 64'd0);
        @(posedge gb_clk); #1;
    endtask

    task automatic abort_reset(input string nm);
        rst = 1'b1;
        expq.delete();
        phase = 0;
        #1;
        chk({nm, "_gb_we"}, 64'(gb_we), 64'd0);
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        repeat (2) @(posedge gb_clk);
        #2 rst = 1'b0;
        @(posedge gb_clk); #1;
        chk({nm, "_gb_addr"}, 64'(gb_addr), 64'd0);
    endtask

    task automatic rd3(input logic [23:0] a, input logic [31:0] d);
        req_addr3 = a; req_valid3 = 1'b1;
        @(negedge gb_clk);
        chk("t6_req_ready", 64'(req_ready3), 64'd1);
        @(posedge gb_clk); #1;
        req_valid3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge gb_clk);
            chk("t6_rsp_valid", 64'(rsp_valid3), 64'(c == 4));
            if (c < 4) begin
                chk("t6_addr_hold", 64'(gb_addr3), 64'(a));
            end else begin
                chk("t6_data", 64'(rsp_data3), 64'(d));
                chk("t6_last", 64'(rsp_last3), 64'd1);
                chk("t6_we", 64'(rsp_we3), 64'd0);
            end
        end
        @(posedge gb_clk); #1;
        chk("t6_idle", 64'(req_ready3), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
        req_valid3 = 1'b0; req_addr3 = '0; rsp_ready3 = 1'b1;
        mem3[24'h000000] = 32'h000000CC;
        repeat (3) @(posedge gb_clk);
        #1;
        chk("rst_gb_addr", 64'(gb_addr), 64'd0);
        chk("rst_gb_dout", 64'(gb_dout), 64'd0);
        chk("rst_gb_we", 64'(gb_we), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_we", 64'(rsp_we), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_last", 64'(rsp_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid3", 64'(rsp_valid3), 64'd0);
        @(negedge gb_clk);
        rst = 1'b0;
        @(posedge gb_clk); #1;

        // 1: single write then single read back
        push(1'b1, 24'h000001, 32'hCECEFACE, 32'h0, 1'b1);
        send(1'b1, 24'h000001, 32'hCECEFACE, 8'd0);
        wait_idle("t1_write_done");
        chk("t1_wr_count", 64'(n_wr), 64'd1);
        chk("t1_mem", 64'(mem1[24'h000001]), 64'hCECEFACE);
        push(1'b0, 24'h000001, 32'h0, 32'hCECEFACE, 1'b1);
        send(1'b0, 24'h000001, 32'h0, 8'd0);
        wait_idle("t1_read_done");

        // 2: four-beat burst from RAM
        mem1[24'h000100] = 32'h11; mem1[24'h000101] = 32'h22;
        mem1[24'h000102] = 32'h33; mem1[24'h000103] = 32'h44;
        push(1'b0, 24'h000100, 32'h0, 32'h11, 1'b0);
        push(1'b0, 24'h000101, 32'h0, 32'h22, 1'b0);
        push(1'b0, 24'h000102, 32'h0, 32'h33, 1'b0);
        push(1'b0, 24'h000103, 32'h0, 32'h44, 1'b1);
        send(1'b0, 24'h000100, 32'h0, 8'd3);
        wait_idle("t2_burst_done");

        // 3: the same burst with rsp_ready high one cycle in three
        slow_rsp = 1'b1;
        push(1'b0, 24'h000100, 32'h0, 32'h11, 1'b0);
        push(1'b0, 24'h000101, 32'h0, 32'h22, 1'b0);
        push(1'b0, 24'h000102, 32'h0, 32'h33, 1'b0);
        push(1'b0, 24'h000103, 32'h0, 32'h44, 1'b1);
        send(1'b0, 24'h000100, 32'h0, 8'd3);
        wait_idle("t3_burst_done");
        slow_rsp = 1'b0;
        @(posedge gb_clk); #1;

        // 4: burst across the top of the address space
        push(1'b0, 24'hFFFFFE, 32'h0, 32'hA5FFFFFE, 1'b0);
        push(1'b0, 24'hFFFFFF, 32'h0, 32'hA5FFFFFF, 1'b0);
        push(1'b0, 24'h000000, 32'h0, 32'hA5000000, 1'b0);
        push(1'b0, 24'h000001, 32'h0, 32'hCECEFACE, 1'b1);
        send(1'b0, 24'hFFFFFE, 32'h0, 8'd3);
        wait_idle("t4_wrap_done");

        // 5a: reset during the write strobe
        push(1'b1, 24'h000050, 32'h12345678, 32'h0, 1'b1);
        send(1'b1, 24'h000050, 32'h12345678, 8'd0);
        chk("t5_we_before_rst", 64'(gb_we), 64'd1);
        abort_reset("t5a");
        chk("t5_no_write", 64'(mem1.exists(24'h000050)), 64'd0);

        // 5b: reset during beat 2 of an 8-beat burst, then a single read
        push(1'b0, 24'h000100, 32'h0, 32'h11, 1'b0);
        push(1'b0, 24'h000101, 32'h0, 32'h22, 1'b0);
        push(1'b0, 24'h000102, 32'h0, 32'h33, 1'b0);
        push(1'b0, 24'h000103, 32'h0, 32'h44, 1'b0);
        for (int i = 4; i < 8; i++)
            push(1'b0, 24'h000100 + 24'(i), 32'h0, 32'hA5000100 + 32'(i), i == 7);
        send(1'b0, 24'h000100, 32'h0, 8'd7);
        n = 0;
        while (expq.size() > 7 && n < 50) begin
            @(negedge gb_clk);
            n++;
        end
        chk("t5_first_beat", 64'(expq.size()), 64'd7);
        @(posedge gb_clk); #2;
        chk("t5_rwait_addr", 64'(gb_addr), 64'h000101);
        abort_reset("t5b");
        push(1'b0, 24'h000102, 32'h0, 32'h33, 1'b1);
        send(1'b0, 24'h000102, 32'h0, 8'd0);
        wait_idle("t5_after_rst_read");
        chk("t5_wr_count", 64'(n_wr), 64'd1);

        // 6: RD_LAT=3 instance
        rd3(24'h000005, 32'hA5000005);
        rd3(24'h000000, 32'h000000CC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
